// File: rtl/pkt_classifier.sv
// pkt_classifier
// Collects BEATS stream beats into one frame and classifies it. The destination IP,
// destination port and payload are taken from fixed bit offsets in the frame. A signature
// field is compared against SIG_VALUE. The result goes out on a valid/ready port:
// m_match=1 selects the buffer path, m_match=0 the host path. Frames that are too short
// or too long are dropped, and err_pulse is raised for one cycle.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   s_data/s_keep  input beat and its byte enables (keep is sampled on the last beat only)
//   s_valid/s_last input beat qualifier and end-of-frame marker
//   s_ready        input accept (low while a classified frame waits downstream)
//   m_valid/m_ready  classified frame handshake
//   m_payload, m_dest_ip, m_dest_port, m_match, m_last_keep  classified frame fields
//   err_pulse      one-cycle pulse per dropped malformed frame
//
// Optional build macro: PKT_CLASSIFIER_STATS_EN
//   Adds the saturating 32-bit counters stat_match, stat_nomatch and stat_err.
module pkt_classifier #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int BEATS      = 3,
  parameter int IP_LSB     = 624,
  parameter int PORT_LSB   = 480,
  parameter int PAYLOAD_W  = 336,
  parameter int SIG_W      = 64,
  parameter int SIG_LSB    = 272,
  parameter logic [SIG_W-1:0] SIG_VALUE = 64'h89504E470D0A1A0A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0] s_keep,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PAYLOAD_W-1:0]  m_payload,
  output logic [31:0]           m_dest_ip,
  output logic [15:0]           m_dest_port,
  output logic                  m_match,
  output logic [KEEP_WIDTH-1:0] m_last_keep,
`ifdef PKT_CLASSIFIER_STATS_EN
  output logic [31:0]           stat_match,
  output logic [31:0]           stat_nomatch,
  output logic [31:0]           stat_err,
`endif
  output logic                  err_pulse
);

  localparam int FW    = DATA_WIDTH * BEATS;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      beatCnt_q, beatCnt_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [FW-1:0]         fullFrame;
  logic                  mValid_q, mValid_d;
  logic [PAYLOAD_W-1:0]  mPayload_q, mPayload_d;
  logic [31:0]           mDestIp_q, mDestIp_d;
  logic [15:0]           mDestPort_q, mDestPort_d;
  logic                  mMatch_q, mMatch_d;
  logic [KEEP_WIDTH-1:0] mLastKeep_q, mLastKeep_d;
  logic                  err_q, err_d;
  logic                  beatFire;

  assign s_ready  = (state_q != HOLD);
  assign beatFire = s_valid && s_ready;

  // The frame as it would look with the current beat written into its slot. This lets
  // the last beat be classified in the same cycle it arrives, without waiting a cycle
  // for it to land in frame_q.
  always_comb begin
    fullFrame = frame_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beatCnt_q == CNT_W'(k)) begin
        fullFrame[FW-1-k*DATA_WIDTH -: DATA_WIDTH] = s_data;
      end
    end
  end

  // Frame assembly and classification FSM. A malformed frame never reaches the
  // output registers. The assembly state is wiped and err_pulse fires after the
  // offending s_last.
  always_comb begin
    state_d     = state_q;
    beatCnt_d   = beatCnt_q;
    frame_d     = frame_q;
    mValid_d    = mValid_q;
    mPayload_d  = mPayload_q;
    mDestIp_d   = mDestIp_q;
    mDestPort_d = mDestPort_q;
    mMatch_d    = mMatch_q;
    mLastKeep_d = mLastKeep_q;
    err_d       = 1'b0;
    case (state_q)
      COLLECT: begin
        if (beatFire) begin
          if (beatCnt_q != LAST_BEAT) begin
            if (s_last) begin
              err_d     = 1'b1;
              beatCnt_d = '0;
              frame_d   = '0;
            end else begin
              frame_d   = fullFrame;
              beatCnt_d = beatCnt_q + CNT_W'(1);
            end
          end else if (s_last) begin
            frame_d     = fullFrame;
            mPayload_d  = fullFrame[PAYLOAD_W-1:0];
            mDestIp_d   = fullFrame[IP_LSB +: 32];
            mDestPort_d = fullFrame[PORT_LSB +: 16];
            mMatch_d    = (fullFrame[SIG_LSB +: SIG_W] == SIG_VALUE);
            mLastKeep_d = s_keep;
            mValid_d    = 1'b1;
            state_d     = HOLD;
          end else begin
            beatCnt_d = '0;
            frame_d   = '0;
            state_d   = DROP;
          end
        end
      end
      DROP: begin
        if (beatFire && s_last) begin
          err_d   = 1'b1;
          state_d = COLLECT;
        end
      end
      HOLD: begin
        if (m_ready) begin
          mValid_d  = 1'b0;
          frame_d   = '0;
          beatCnt_d = '0;
          state_d   = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State registers. Reset discards any partial frame without an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      beatCnt_q   <= '0;
      frame_q     <= '0;
      mValid_q    <= 1'b0;
      mPayload_q  <= '0;
      mDestIp_q   <= '0;
      mDestPort_q <= '0;
      mMatch_q    <= 1'b0;
      mLastKeep_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beatCnt_q   <= beatCnt_d;
      frame_q     <= frame_d;
      mValid_q    <= mValid_d;
      mPayload_q  <= mPayload_d;
      mDestIp_q   <= mDestIp_d;
      mDestPort_q <= mDestPort_d;
      mMatch_q    <= mMatch_d;
      mLastKeep_q <= mLastKeep_d;
      err_q       <= err_d;
    end
  end

  assign m_valid     = mValid_q;
  assign m_payload   = mPayload_q;
  assign m_dest_ip   = mDestIp_q;
  assign m_dest_port = mDestPort_q;
  assign m_match     = mMatch_q;
  assign m_last_keep = mLastKeep_q;
  assign err_pulse   = err_q;

`ifdef PKT_CLASSIFIER_STATS_EN
  logic [31:0] statMatch_q, statNomatch_q, statErr_q;

  // Saturating counters. Match/nomatch count downstream accepts. The error count
  // steps on the same edge that raises err_pulse, so both appear together.
  always_ff @(posedge clk) begin
    if (rst) begin
      statMatch_q   <= '0;
      statNomatch_q <= '0;
      statErr_q     <= '0;
    end else begin
      if (mValid_q && m_ready) begin
        if (mMatch_q) begin
          if (statMatch_q != 32'hFFFFFFFF) statMatch_q <= statMatch_q + 32'd1;
        end else begin
          if (statNomatch_q != 32'hFFFFFFFF) statNomatch_q <= statNomatch_q + 32'd1;
        end
      end
      if (err_d && (statErr_q != 32'hFFFFFFFF)) begin
        statErr_q <= statErr_q + 32'd1;
      end
    end
  end

  assign stat_match   = statMatch_q;
  assign stat_nomatch = statNomatch_q;
  assign stat_err     = statErr_q;
`endif

endmodule

// File: tb/tb_pkt_classifier.sv
// tb_pkt_classifier
// Drives directed and randomized frames into pkt_classifier. A frame-level reference
// model turns the accepted beats into expected outputs: exactly BEATS beats give a
// classified frame, and any other length gives an error pulse. Outputs are compared
// every cycle on the falling clock edge.
module tb_pkt_classifier;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int BEATS = 3;
  localparam int FW = DW * BEATS;
  localparam int PW = 336;
  localparam logic [63:0] PNG = 64'h89504E470D0A1A0A;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_payload;
  logic [31:0]   m_dest_ip;
  logic [15:0]   m_dest_port;
  logic          m_match;
  logic [KW-1:0] m_last_keep;
  logic          err_pulse;
`ifdef PKT_CLASSIFIER_STATS_EN
  logic [31:0]   stat_match, stat_nomatch, stat_err;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int readyMode = 0;
  bit checkEn = 1'b0;

  pkt_classifier dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_payload(m_payload), .m_dest_ip(m_dest_ip),
    .m_dest_port(m_dest_port), .m_match(m_match), .m_last_keep(m_last_keep),
`ifdef PKT_CLASSIFIER_STATS_EN
    .stat_match(stat_match), .stat_nomatch(stat_nomatch), .stat_err(stat_err),
`endif
    .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] mdlBeats[$];
  bit            mdlHolding = 1'b0;
  logic [PW-1:0] expPayload = '0;
  logic [31:0]   expIp = '0;
  logic [15:0]   expPort = '0;
  bit            expMatch = 1'b0;
  logic [KW-1:0] expKeep = '0;
  bit            expErr = 1'b0;
  logic [31:0]   expStatMatch = 0, expStatNomatch = 0, expStatErr = 0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: gather accepted beats and judge the frame by its length at s_last.
  always @(posedge clk) begin
    logic [FW-1:0] frame;
    if (rst) begin
      mdlBeats.delete();
      mdlHolding = 1'b0;
      expPayload = '0; expIp = '0; expPort = '0; expMatch = 1'b0; expKeep = '0;
      expErr = 1'b0;
      expStatMatch = 0; expStatNomatch = 0; expStatErr = 0;
    end else begin
      expErr = 1'b0;
      if (mdlHolding) begin
        if (m_ready) begin
          mdlHolding = 1'b0;
          if (expMatch) begin
            if (expStatMatch != 32'hFFFFFFFF) expStatMatch++;
          end else begin
            if (expStatNomatch != 32'hFFFFFFFF) expStatNomatch++;
          end
        end
      end else if (s_valid) begin
        mdlBeats.push_back(s_data);
        if (s_last) begin
          if (mdlBeats.size() == BEATS) begin
            frame = '0;
            foreach (mdlBeats[i]) frame = (frame << DW) | FW'(mdlBeats[i]);
            expPayload = frame[PW-1:0];
            expIp      = frame[624 +: 32];
            expPort    = frame[480 +: 16];
            expMatch   = (frame[272 +: 64] == PNG);
            expKeep    = s_keep;
            mdlHolding = 1'b1;
          end else begin
            expErr = 1'b1;
            if (expStatErr != 32'hFFFFFFFF) expStatErr++;
          end
          mdlBeats.delete();
        end
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_valid", m_valid, mdlHolding);
      checkOutput("s_ready", s_ready, !mdlHolding);
      checkOutput("err_pulse", err_pulse, expErr);
      checkOutput("m_payload", m_payload, expPayload);
      checkOutput("m_dest_ip", m_dest_ip, expIp);
      checkOutput("m_dest_port", m_dest_port, expPort);
      checkOutput("m_match", m_match, expMatch);
      checkOutput("m_last_keep", m_last_keep, expKeep);
`ifdef PKT_CLASSIFIER_STATS_EN
      checkOutput("stat_match", stat_match, expStatMatch);
      checkOutput("stat_nomatch", stat_nomatch, expStatNomatch);
      checkOutput("stat_err", stat_err, expStatErr);
`endif
    end
  end

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (readyMode)
        0: m_ready = 1'b1;
        1: m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [FW-1:0] makeFrame(input logic [31:0] ip, input logic [15:0] port,
                                               input logic [63:0] sig);
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    f[624 +: 32] = ip;
    f[480 +: 16] = port;
    f[272 +: 64] = sig;
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Present one beat and hold it until the model says it was accepted. Returns just
  // after the accepting rising edge.
  task automatic sendBeat(input logic [DW-1:0] d, input bit last, input int gap);
    bit readyNow;
    int waited = 0;
    if (gap > 0) idle(gap);
    @(negedge clk);
    s_data  = d;
    s_last  = last;
    s_keep  = $urandom;
    s_valid = 1'b1;
    forever begin
      readyNow = !mdlHolding;
      @(posedge clk);
      if (readyNow) break;
      waited++;
      if (waited > 1000) begin
        checkOutput("beat_accept_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [FW-1:0] f, input int nBeats, input int gapMax);
    logic [DW-1:0] b;
    for (int k = 0; k < nBeats; k++) begin
      if (k < BEATS) b = f[FW-1-k*DW -: DW];
      else           b = {8{$urandom}};
      sendBeat(b, k == nBeats - 1, (gapMax > 0) ? $urandom_range(0, gapMax) : 0);
    end
  endtask

  task automatic applyStimulus();
    logic [FW-1:0] f, f2;
    int nBeats;

    // Test 1: PNG frame, always ready.
    readyMode = 0;
    f = makeFrame(32'hC0A80001, 16'd21, PNG);
    sendFrame(f, 3, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t1_valid_latency", m_valid, 1);
    checkOutput("t1_match", m_match, 1);
    checkOutput("t1_ip", m_dest_ip, 32'hC0A80001);
    checkOutput("t1_port", m_dest_port, 16'd21);
    checkOutput("t1_model_payload", expPayload, f[PW-1:0]);
    idle(1);
`ifdef PKT_CLASSIFIER_STATS_EN
    checkOutput("t1_stat_match", stat_match, 1);
`endif
    idle(2);

    // Test 2: same frame with zero signature.
    f2 = f;
    f2[272 +: 64] = '0;
    sendFrame(f2, 3, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t2_valid", m_valid, 1);
    checkOutput("t2_match", m_match, 0);
    checkOutput("t2_payload", m_payload, f2[PW-1:0]);
    idle(2);

    // Test 3: short frame, then a good one.
    sendFrame(f, 2, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t3_err", err_pulse, 1);
    checkOutput("t3_no_valid", m_valid, 0);
    @(negedge clk);
    checkOutput("t3_err_one_cycle", err_pulse, 0);
    sendFrame(f, 3, 1);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t3_after_valid", m_valid, 1);
    checkOutput("t3_after_ip", m_dest_ip, 32'hC0A80001);
    idle(2);

    // Test 4: long frame.
    sendFrame(f, 5, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t4_err", err_pulse, 1);
    checkOutput("t4_no_valid", m_valid, 0);
    idle(2);

    // Test 5: downstream stall with beats offered.
    readyMode = 1;
    sendFrame(f, 3, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_data  = {8{$urandom}};
      checkOutput("t5_valid_held", m_valid, 1);
      checkOutput("t5_sready_low", s_ready, 0);
      checkOutput("t5_ip_stable", m_dest_ip, 32'hC0A80001);
    end
    @(negedge clk);
    s_valid = 1'b0;
    readyMode = 0;
    idle(3);
    checkOutput("t5_consumed", m_valid, 0);

    // Test 6: reset in the middle of a frame.
    sendFrame(f, 2, 0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_valid_zero", m_valid, 0);
    checkOutput("t6_ip_zero", m_dest_ip, 0);
    checkOutput("t6_err_zero", err_pulse, 0);
`ifdef PKT_CLASSIFIER_STATS_EN
    checkOutput("t6_stat_match_zero", stat_match, 0);
`endif
    f = makeFrame(32'h0A000002, 16'd443, PNG);
    sendFrame(f, 3, 0);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t6_valid", m_valid, 1);
    checkOutput("t6_ip", m_dest_ip, 32'h0A000002);
    checkOutput("t6_port", m_dest_port, 16'd443);
    idle(2);

    // Randomized traffic with random backpressure and occasional resets.
    readyMode = 2;
    for (int n = 0; n < 150; n++) begin
      nBeats = ($urandom_range(0, 9) < 7) ? 3 : $urandom_range(1, 5);
      f = makeFrame($urandom, 16'($urandom), ($urandom_range(0, 1) == 1) ? PNG : {$urandom, $urandom});
      sendFrame(f, nBeats, 2);
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    readyMode = 0;
    idle(5);
  endtask

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_keep  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
